sd_spi_arbiter: RTL and testbench
=================================

// Module: sd_spi_arbiter
// PURPOSE
//  Shares the single SD-card SPI link (card[1:0], spi_clock, spi_dataout, spi_datain) between two requesters:
//   - the Z80 port-0xEB/0xE7 path (CPU side);
//   - the power-on sector loader (LDR side).
//  Sequences one 8-bit SPI mode-0 transfer per grant and owns the chip-select outputs.
//  Sits between the DivMMC port decoder and the SD socket pins.
// PARAMETERS
//  CLK_DIV    1      clocks per SPI half-period (>=1); spi_clock = clock/(2*CLK_DIV)
//  IDLE_BYTE  8'hFF  byte shifted out on read-only transfers (wr=0)
// PORTS
//  clock        in   1  system clock; all logic on posedge
//  reset        in   1  synchronous, active-high reset
//  cpu_req      in   1  level: CPU wants one byte transfer
//  cpu_wr       in   1  1 = send cpu_wdata, 0 = send IDLE_BYTE
//  cpu_wdata    in   8  byte to send
//  cpu_cs       in   2  card selects to drive while CPU owns the bus (active low)
//  cpu_rdata    out  8  last byte received for CPU; holds until next CPU done
//  cpu_busy     out  1  CPU request pending or in progress
//  cpu_done     out  1  one-clock pulse, cpu_rdata valid
//  ldr_req      in   1  level: loader wants one byte transfer
//  ldr_wr       in   1  as cpu_wr
//  ldr_wdata    in   8  byte to send
//  ldr_cs       in   2  card selects for loader ownership
//  ldr_lock     in   1  loader keeps ownership between bytes (multi-byte command/sector)
//  ldr_rdata    out  8  last byte received for loader
//  ldr_done     out  1  one-clock pulse, ldr_rdata valid
//  card         out  2  SD chip selects (active low)
//  spi_clock    out  1  SPI SCK, idle low
//  spi_dataout  out  1  MOSI
//  spi_datain   in   1  MISO
// BEHAVIOUR
//  Reset values:
//   - card=2'b11, spi_clock=0, spi_dataout=1;
//   - cpu_rdata=ldr_rdata=8'hFF;
//   - done pulses 0, cpu_busy=0;
//   - owner=CPU, rr_last=LDR.
//  Reset mid-transfer aborts immediately; no done pulse is issued.
//  FSM:
//   - IDLE -> LOAD when a requester is selected;
//   - LOAD -> SHIFT;
//   - SHIFT -> DONE after 16*CLK_DIV clocks;
//   - DONE -> IDLE.
//  Arbitration (IDLE only):
//   - if owner==LDR and ldr_lock=1: only LDR is eligible; CPU waits with cpu_busy=1;
//   - else if both request: grant the one != rr_last (round robin);
//   - else grant the single requester;
//   - grant updates owner and rr_last.
//  LOAD: shift reg <= wr ? wdata : IDLE_BYTE; card <= owner cs; spi_dataout = sreg[7].
//  SHIFT:
//   - half-period counter counts 0..CLK_DIV-1; spi_clock toggles at each wrap, 16 toggles total;
//   - rising edge: sample spi_datain into rx LSB;
//   - falling edge: shift tx left, fill with 1.
//  DONE:
//   - rx byte -> owner's rdata; owner's done=1 for one clock;
//   - spi_clock=0, spi_dataout=1.
//  Latency: req seen in IDLE at cycle n -> done at n+2+16*CLK_DIV (n+18 for CLK_DIV=1).
//  Request handling:
//   - req is sampled only in IDLE;
//   - a req still high in the IDLE after done starts a new transfer (back-to-back);
//   - requesters drop req on the clock after done for a single byte.
//  card holds the last owner's cs while IDLE (CS stays low across bytes).
//  card changes only in LOAD; a new owner's cs is applied 1 clock before the first SCK edge.
//  cs/wdata changes during SHIFT are ignored.
//  ldr_lock falling while IDLE releases ownership on that same IDLE cycle.
//  cpu_busy = cpu_req | (owner==CPU & state!=IDLE).
// STRUCTURE
//  Shared package sd_spi_pkg:
//   - state encoding IDLE/LOAD/SHIFT/DONE;
//   - OWNER_CPU/OWNER_LDR;
//   - CS_NONE=2'b11, IDLE_BYTE default.
//  One sub-module, spi_byte_shifter:
//   - tx/rx shift regs, half-period counter, edge count;
//   - ports start/busy/done/txbyte/rxbyte plus SPI pins.
//  The arbiter FSM and cs/rdata registers stay in the top level.
// TESTING
//  1. CPU only, CLK_DIV=1, cpu_wr=1, wdata=8'hA5, cs=2'b10, MISO model returns 8'h3C
//     -> MOSI bits 1,0,1,0,0,1,0,1; card=2'b10; cpu_rdata=8'h3C;
//     -> cpu_done exactly 18 clocks after req; 8 SCK pulses.
//  2. Read-only: cpu_wr=0, MISO=8'hFE -> MOSI stays 1 for all 8 bits; cpu_rdata=8'hFE.
//  3. cpu_req and ldr_req rise on the same clock after reset (rr_last=LDR)
//     -> CPU served first, then LDR; ldr_done ~18 clocks after cpu_done.
//  4. LDR with ldr_lock=1 for 4 bytes while cpu_req held
//     -> all 4 LDR bytes complete, card=ldr_cs throughout;
//     -> CPU granted only after lock drops; card switches to cpu_cs in LOAD.
//  5. reset=1 at SCK edge 7 of a transfer
//     -> next clock: card=2'b11, spi_clock=0, spi_dataout=1, state IDLE, no done pulse.
//  6. CLK_DIV=3 -> SCK period 6 clocks; done at n+50.

Source files
------------

// File: rtl/sd_spi_pkg.sv
// Shared definitions for the SD-card SPI arbiter.
//   state_t  : arbiter sequencing states IDLE/LOAD/SHIFT/DONE
//   owner_t  : which requester currently owns the SPI link
//   CS_NONE  : both card selects released (active low)
//   tx_byte(): byte actually shifted out for a request (write data or idle filler)
package sd_spi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  typedef enum logic {
    OWNER_CPU = 1'b0,
    OWNER_LDR = 1'b1
  } owner_t;

  localparam logic [1:0] CS_NONE           = 2'b11;
  localparam logic [7:0] IDLE_BYTE_DEFAULT = 8'hFF;

  // Read-only transfers still have to clock something out; the card expects 1s.
  function automatic logic [7:0] tx_byte(input logic       wr,
                                         input logic [7:0] wdata,
                                         input logic [7:0] idle_byte);
    return wr ? wdata : idle_byte;
  endfunction

endpackage

// File: rtl/spi_byte_shifter.sv
// One 8-bit SPI mode-0 transfer engine.
// Ports:
//   i_clock, i_reset : system clock, synchronous active-high reset
//   i_start          : load i_txbyte and begin a transfer (one clock)
//   i_txbyte         : byte to send, MSB first
//   o_busy           : transfer in progress
//   o_done           : high on the clock that makes the 16th SCK toggle
//   o_rxbyte         : received byte (complete when o_done is high)
//   o_sck/o_mosi     : SPI clock (idle low) and data out (idle high)
//   i_miso           : SPI data in
module spi_byte_shifter #(
  parameter int CLK_DIV = 1
) (
  input  logic       i_clock,
  input  logic       i_reset,
  input  logic       i_start,
  input  logic [7:0] i_txbyte,
  output logic       o_busy,
  output logic       o_done,
  output logic [7:0] o_rxbyte,
  output logic       o_sck,
  output logic       o_mosi,
  input  logic       i_miso
);

  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [CW-1:0] r_div;
  logic [3:0]    r_edges;
  logic          r_busy;
  logic          r_sck;
  logic [7:0]    r_tx;
  logic [7:0]    r_rx;
  logic          w_wrap;

  assign w_wrap = (r_div == CW'(CLK_DIV - 1));

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_div   <= '0;
      r_edges <= '0;
      r_busy  <= 1'b0;
      r_sck   <= 1'b0;
      r_tx    <= 8'hFF;
      r_rx    <= 8'hFF;
    end else if (i_start) begin
      r_div   <= '0;
      r_edges <= '0;
      r_busy  <= 1'b1;
      r_sck   <= 1'b0;
      r_tx    <= i_txbyte;
    end else if (r_busy) begin
      if (w_wrap) begin
        r_div   <= '0;
        r_sck   <= ~r_sck;
        r_edges <= r_edges + 4'd1;
        // Mode 0: sample on the rising edge, advance MOSI on the falling edge.
        // Filling with 1s leaves MOSI high once the byte is out.
        if (!r_sck) begin
          r_rx <= {r_rx[6:0], i_miso};
        end else begin
          r_tx <= {r_tx[6:0], 1'b1};
        end
        if (r_edges == 4'd15) begin
          r_busy <= 1'b0;
        end
      end else begin
        r_div <= r_div + CW'(1);
      end
    end
  end

  // The last rising edge (toggle 15) already completed r_rx, so the byte is
  // valid on the clock that makes the final falling edge.
  assign o_done   = r_busy & w_wrap & (r_edges == 4'd15);
  assign o_busy   = r_busy;
  assign o_rxbyte = r_rx;
  assign o_sck    = r_sck;
  assign o_mosi   = r_tx[7];

endmodule

// File: rtl/sd_spi_arbiter.sv
// Shares the SD-card SPI link between the CPU port path and the sector loader.
// Grants one byte transfer at a time, owns the card chip-selects and returns
// the received byte to whichever requester was served.
// Ports:
//   clock, reset                     : system clock, synchronous active-high reset
//   cpu_req/wr/wdata/cs              : CPU request, write flag, tx byte, selects
//   cpu_rdata/busy/done              : CPU rx byte, pending/in-progress, done pulse
//   ldr_req/wr/wdata/cs/lock         : loader request, plus lock to keep ownership
//   ldr_rdata/done                   : loader rx byte, done pulse
//   card, spi_clock, spi_dataout     : SD chip selects (active low), SCK, MOSI
//   spi_datain                       : MISO
module sd_spi_arbiter
  import sd_spi_pkg::*;
#(
  parameter int         CLK_DIV   = 1,
  parameter logic [7:0] IDLE_BYTE = IDLE_BYTE_DEFAULT
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cpu_req,
  input  logic       cpu_wr,
  input  logic [7:0] cpu_wdata,
  input  logic [1:0] cpu_cs,
  output logic [7:0] cpu_rdata,
  output logic       cpu_busy,
  output logic       cpu_done,
  input  logic       ldr_req,
  input  logic       ldr_wr,
  input  logic [7:0] ldr_wdata,
  input  logic [1:0] ldr_cs,
  input  logic       ldr_lock,
  output logic [7:0] ldr_rdata,
  output logic       ldr_done,
  output logic [1:0] card,
  output logic       spi_clock,
  output logic       spi_dataout,
  input  logic       spi_datain
);

  state_t     r_state;
  owner_t     r_owner;
  owner_t     r_rr_last;
  logic [1:0] r_card;
  logic [7:0] r_cpu_rdata;
  logic [7:0] r_ldr_rdata;
  logic       r_cpu_done;
  logic       r_ldr_done;

  logic       w_grant_valid;
  owner_t     w_grant_owner;
  logic [7:0] w_txbyte;
  logic       w_start;
  logic       w_shift_busy;
  logic       w_shift_done;
  logic [7:0] w_rxbyte;

  // A locked loader keeps the link; otherwise simultaneous requests alternate.
  always_comb begin
    w_grant_valid = 1'b0;
    w_grant_owner = r_owner;
    if ((r_owner == OWNER_LDR) && ldr_lock) begin
      w_grant_valid = ldr_req;
      w_grant_owner = OWNER_LDR;
    end else if (cpu_req && ldr_req) begin
      w_grant_valid = 1'b1;
      w_grant_owner = (r_rr_last == OWNER_LDR) ? OWNER_CPU : OWNER_LDR;
    end else if (cpu_req) begin
      w_grant_valid = 1'b1;
      w_grant_owner = OWNER_CPU;
    end else if (ldr_req) begin
      w_grant_valid = 1'b1;
      w_grant_owner = OWNER_LDR;
    end
  end

  // Write data is taken live in LOAD; later changes do not reach the shifter.
  assign w_txbyte = (r_owner == OWNER_CPU) ? tx_byte(cpu_wr, cpu_wdata, IDLE_BYTE)
                                           : tx_byte(ldr_wr, ldr_wdata, IDLE_BYTE);
  assign w_start  = (r_state == ST_LOAD);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_owner     <= OWNER_CPU;
      r_rr_last   <= OWNER_LDR;
      r_card      <= CS_NONE;
      r_cpu_rdata <= 8'hFF;
      r_ldr_rdata <= 8'hFF;
      r_cpu_done  <= 1'b0;
      r_ldr_done  <= 1'b0;
    end else begin
      r_cpu_done <= 1'b0;
      r_ldr_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_grant_valid && !w_shift_busy) begin
            r_owner   <= w_grant_owner;
            r_rr_last <= w_grant_owner;
            r_state   <= ST_LOAD;
          end
        end
        ST_LOAD: begin
          // Selects move only here, one clock ahead of the first SCK edge;
          // in IDLE they keep the last owner's value so CS spans bytes.
          r_card  <= (r_owner == OWNER_CPU) ? cpu_cs : ldr_cs;
          r_state <= ST_SHIFT;
        end
        ST_SHIFT: begin
          if (w_shift_done) begin
            r_state <= ST_DONE;
            if (r_owner == OWNER_CPU) begin
              r_cpu_rdata <= w_rxbyte;
              r_cpu_done  <= 1'b1;
            end else begin
              r_ldr_rdata <= w_rxbyte;
              r_ldr_done  <= 1'b1;
            end
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  spi_byte_shifter #(
    .CLK_DIV (CLK_DIV)
  ) u_shifter (
    .i_clock  (clock),
    .i_reset  (reset),
    .i_start  (w_start),
    .i_txbyte (w_txbyte),
    .o_busy   (w_shift_busy),
    .o_done   (w_shift_done),
    .o_rxbyte (w_rxbyte),
    .o_sck    (spi_clock),
    .o_mosi   (spi_dataout),
    .i_miso   (spi_datain)
  );

  assign card      = r_card;
  assign cpu_rdata = r_cpu_rdata;
  assign ldr_rdata = r_ldr_rdata;
  assign cpu_done  = r_cpu_done;
  assign ldr_done  = r_ldr_done;
  assign cpu_busy  = cpu_req | ((r_owner == OWNER_CPU) && (r_state != ST_IDLE));

endmodule

// File: tb/tb_sd_spi_arbiter.sv
// Bench for sd_spi_arbiter: directed scenarios plus randomized request rounds
// scored against a transaction-level arbitration model and an SPI slave model.
module tb_sd_spi_arbiter;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic       reset;
  logic       cpu_req, cpu_wr, cpu_busy, cpu_done;
  logic [7:0] cpu_wdata, cpu_rdata;
  logic [1:0] cpu_cs;
  logic       ldr_req, ldr_wr, ldr_lock, ldr_done;
  logic [7:0] ldr_wdata, ldr_rdata;
  logic [1:0] ldr_cs, card;
  logic       spi_clock, spi_dataout, spi_datain;

  // second instance exercising a slower SPI clock, CPU side only
  logic       c3_req, c3_wr, c3_busy, c3_done, l3_done;
  logic [7:0] c3_wdata, c3_rdata, l3_rdata;
  logic [1:0] c3_cs, card3;
  logic       sck3, mosi3, miso3;

  sd_spi_arbiter #(.CLK_DIV(1), .IDLE_BYTE(8'hFF)) u_dut (
    .clock(clock), .reset(reset),
    .cpu_req(cpu_req), .cpu_wr(cpu_wr), .cpu_wdata(cpu_wdata), .cpu_cs(cpu_cs),
    .cpu_rdata(cpu_rdata), .cpu_busy(cpu_busy), .cpu_done(cpu_done),
    .ldr_req(ldr_req), .ldr_wr(ldr_wr), .ldr_wdata(ldr_wdata), .ldr_cs(ldr_cs),
    .ldr_lock(ldr_lock), .ldr_rdata(ldr_rdata), .ldr_done(ldr_done),
    .card(card), .spi_clock(spi_clock), .spi_dataout(spi_dataout), .spi_datain(spi_datain)
  );

  sd_spi_arbiter #(.CLK_DIV(3), .IDLE_BYTE(8'hFF)) u_dut3 (
    .clock(clock), .reset(reset),
    .cpu_req(c3_req), .cpu_wr(c3_wr), .cpu_wdata(c3_wdata), .cpu_cs(c3_cs),
    .cpu_rdata(c3_rdata), .cpu_busy(c3_busy), .cpu_done(c3_done),
    .ldr_req(1'b0), .ldr_wr(1'b0), .ldr_wdata(8'h00), .ldr_cs(2'b11),
    .ldr_lock(1'b0), .ldr_rdata(l3_rdata), .ldr_done(l3_done),
    .card(card3), .spi_clock(sck3), .spi_dataout(mosi3), .spi_datain(miso3)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- SPI slave / bus monitors ----------------
  int         arm_seq = 0, arm_seen = 0;
  logic [7:0] arm_b1 = 8'hFF, arm_b3 = 8'hFF;
  logic [7:0] s_tx = 8'hFF, s3_tx = 8'hFF;
  logic       s_prev = 1'b0, s3_prev = 1'b0;
  int         s_falls = 0, m_bits = 0, toggles = 0, rises = 0;
  logic [7:0] m_mosi = 8'h00, m3_byte = 8'h00;
  logic [1:0] m_cs = 2'b11;
  int         rises3 = 0, last_rise3 = 0, period3 = 0;
  logic [7:0] miso_q[$], mosi_q[$], d_dat_q[$];
  logic [1:0] cs_q[$];
  int         d_own_q[$], d_cyc_q[$];

  assign spi_datain = s_tx[7];
  assign miso3      = s3_tx[7];

  always @(negedge clock) begin
    if (arm_seq != arm_seen) begin
      arm_seen = arm_seq;
      s_tx = arm_b1; s_falls = 0; m_bits = 0; toggles = 0; rises = 0;
      miso_q.delete(); mosi_q.delete(); cs_q.delete();
      d_own_q.delete(); d_dat_q.delete(); d_cyc_q.delete();
      miso_q.push_back(arm_b1);
      s3_tx = arm_b3; rises3 = 0; period3 = 0;
    end
    if (spi_clock !== s_prev) begin
      toggles++;
      if (spi_clock === 1'b1) begin
        rises++;
        if (m_bits == 0) m_cs = card;
        m_mosi = {m_mosi[6:0], spi_dataout};
        m_bits++;
        if (m_bits == 8) begin
          mosi_q.push_back(m_mosi); cs_q.push_back(m_cs); m_bits = 0;
        end
      end else begin
        s_tx = {s_tx[6:0], 1'b1};
        s_falls++;
        if (s_falls == 8) begin
          s_falls = 0; s_tx = 8'($urandom); miso_q.push_back(s_tx);
        end
      end
    end
    s_prev = spi_clock;
    if (sck3 !== s3_prev) begin
      if (sck3 === 1'b1) begin
        rises3++;
        if (rises3 > 1) period3 = cyc - last_rise3;
        last_rise3 = cyc;
        m3_byte = {m3_byte[6:0], mosi3};
      end else begin
        s3_tx = {s3_tx[6:0], 1'b1};
      end
    end
    s3_prev = sck3;
    if (cpu_done === 1'b1) begin
      d_own_q.push_back(0); d_dat_q.push_back(cpu_rdata); d_cyc_q.push_back(cyc);
    end
    if (ldr_done === 1'b1) begin
      d_own_q.push_back(1); d_dat_q.push_back(ldr_rdata); d_cyc_q.push_back(cyc);
    end
  end

  task automatic arm(input logic [7:0] b1, input logic [7:0] b3);
    arm_b1 = b1; arm_b3 = b3; arm_seq++;
    repeat (2) @(negedge clock);
  endtask

  // ---------------- reference model state ----------------
  int mdl_owner = 0;  // 0 = CPU, 1 = LDR
  int mdl_rr    = 1;

  task automatic do_reset();
    reset = 1'b1; cpu_req = 1'b0; ldr_req = 1'b0; ldr_lock = 1'b0; c3_req = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b0; mdl_owner = 0; mdl_rr = 1;
    @(negedge clock);
  endtask

  function automatic logic [1:0] pick_cs();
    case ($urandom_range(0, 2))
      0:       return 2'b10;
      1:       return 2'b01;
      default: return 2'b00;
    endcase
  endfunction

  task automatic cpu_single(input logic wr, input logic [7:0] wd, input logic [1:0] cs,
                            input logic [7:0] mb, output int lat);
    int t0, t;
    arm(mb, 8'hFF);
    cpu_wr = wr; cpu_wdata = wd; cpu_cs = cs; cpu_req = 1'b1;
    t0 = cyc; t = 0;
    do begin @(negedge clock); t++; end while (cpu_done !== 1'b1 && t < 200);
    if (t >= 200) chk("cpu_single_done", cpu_done, 1);
    lat = cyc - t0;
    cpu_req = 1'b0;
    repeat (3) @(negedge clock);
  endtask

  // One round: each agent behaves as a requester would; the model predicts
  // the service order from the arbitration rules alone.
  task automatic run_round(input int cpu_n, input int ldr_n, input bit lock);
    logic       c_wr;
    logic [7:0] c_wd;
    logic [1:0] c_cs, l_cs;
    logic       l_wr[4];
    logic [7:0] l_wd[4];
    int         exp_own[8];
    logic [7:0] exp_tx[8];
    logic [1:0] exp_cs[8];
    int         n, c, l, g, idx, m;
    c_wr = 1'($urandom); c_wd = 8'($urandom); c_cs = pick_cs(); l_cs = pick_cs();
    for (int i = 0; i < 4; i++) begin l_wr[i] = 1'($urandom); l_wd[i] = 8'($urandom); end
    n = 0; c = cpu_n; l = ldr_n;
    while (c + l > 0) begin
      if (mdl_owner == 1 && lock && l > 0) g = 1;
      else if (c > 0 && l > 0)             g = (mdl_rr == 1) ? 0 : 1;
      else                                 g = (c > 0) ? 0 : 1;
      mdl_owner = g; mdl_rr = g; exp_own[n] = g;
      if (g == 0) begin
        exp_tx[n] = c_wr ? c_wd : 8'hFF; exp_cs[n] = c_cs; c--;
      end else begin
        idx = ldr_n - l;
        exp_tx[n] = l_wr[idx] ? l_wd[idx] : 8'hFF; exp_cs[n] = l_cs; l--;
      end
      n++;
    end
    arm(8'($urandom), 8'hFF);
    fork
      begin
        if (cpu_n > 0) begin
          int t;
          cpu_wr = c_wr; cpu_wdata = c_wd; cpu_cs = c_cs; cpu_req = 1'b1;
          #1 chk("cpu_busy_req", cpu_busy, 1);
          t = 0;
          do begin @(negedge clock); t++; end while (cpu_done !== 1'b1 && t < 600);
          if (t >= 600) chk("cpu_done_seen", cpu_done, 1);
          cpu_req = 1'b0;
        end
      end
      begin
        for (int i = 0; i < ldr_n; i++) begin
          int t;
          ldr_wr = l_wr[i]; ldr_wdata = l_wd[i]; ldr_cs = l_cs;
          ldr_req = 1'b1; ldr_lock = lock;
          t = 0;
          do begin @(negedge clock); t++; end while (ldr_done !== 1'b1 && t < 600);
          if (t >= 600) chk("ldr_done_seen", ldr_done, 1);
        end
        ldr_req = 1'b0; ldr_lock = 1'b0;
      end
    join
    repeat (4) @(negedge clock);
    chk("xfer_count", d_own_q.size(), n);
    m = n;
    if (d_own_q.size() < m) m = d_own_q.size();
    if (mosi_q.size() < m)  m = mosi_q.size();
    for (int k = 0; k < m; k++) begin
      chk($sformatf("order[%0d]", k), d_own_q[k], exp_own[k]);
      chk($sformatf("mosi[%0d]", k), mosi_q[k], exp_tx[k]);
      chk($sformatf("cs[%0d]", k), cs_q[k], exp_cs[k]);
      chk($sformatf("rdata[%0d]", k), d_dat_q[k], miso_q[k]);
    end
    chk("cpu_busy_idle", cpu_busy, 0);
  endtask

  initial begin
    int lat, t, pulses, t0;
    logic [7:0] b3, w3;
    reset = 1'b1;
    cpu_req = 1'b0; cpu_wr = 1'b0; cpu_wdata = 8'h00; cpu_cs = 2'b11;
    ldr_req = 1'b0; ldr_wr = 1'b0; ldr_wdata = 8'h00; ldr_cs = 2'b11; ldr_lock = 1'b0;
    c3_req = 1'b0; c3_wr = 1'b0; c3_wdata = 8'h00; c3_cs = 2'b11;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    // reset state
    chk("rst_card", card, 2'b11);
    chk("rst_sck", spi_clock, 0);
    chk("rst_mosi", spi_dataout, 1);
    chk("rst_cpu_rdata", cpu_rdata, 8'hFF);
    chk("rst_ldr_rdata", ldr_rdata, 8'hFF);
    chk("rst_cpu_done", cpu_done, 0);
    chk("rst_ldr_done", ldr_done, 0);
    chk("rst_cpu_busy", cpu_busy, 0);

    // single CPU write
    cpu_single(1'b1, 8'hA5, 2'b10, 8'h3C, lat);
    chk("t1_latency", lat, 18);
    chk("t1_rdata", cpu_rdata, 8'h3C);
    chk("t1_mosi", mosi_q.size() > 0 ? mosi_q[0] : 8'hxx, 8'hA5);
    chk("t1_cs", cs_q.size() > 0 ? cs_q[0] : 2'bxx, 2'b10);
    chk("t1_sck_pulses", rises, 8);
    chk("t1_card_hold", card, 2'b10);
    chk("t1_sck_idle", spi_clock, 0);
    chk("t1_mosi_idle", spi_dataout, 1);

    // read-only CPU transfer
    cpu_single(1'b0, 8'($urandom), 2'b01, 8'hFE, lat);
    chk("t2_latency", lat, 18);
    chk("t2_rdata", cpu_rdata, 8'hFE);
    chk("t2_mosi", mosi_q.size() > 0 ? mosi_q[0] : 8'hxx, 8'hFF);

    // simultaneous requests right after reset, then a locked loader burst
    do_reset();
    run_round(1, 1, 1'b0);
    if (d_cyc_q.size() >= 2) begin
      chk("t3_first_is_cpu", d_own_q[0], 0);
      chk("t3_ldr_gap", d_cyc_q[1] - d_cyc_q[0], 19);
    end else begin
      chk("t3_done_count", d_cyc_q.size(), 2);
    end
    run_round(1, 4, 1'b1);

    // reset in the middle of a transfer
    arm(8'($urandom), 8'hFF);
    cpu_wr = 1'b1; cpu_wdata = 8'h5A; cpu_cs = 2'b00; cpu_req = 1'b1;
    t = 0;
    while (toggles < 7 && t < 100) begin @(negedge clock); t++; end
    if (t >= 100) chk("t5_sck_edges", toggles, 7);
    reset = 1'b1; cpu_req = 1'b0;
    @(negedge clock);
    reset = 1'b0; mdl_owner = 0; mdl_rr = 1;
    chk("t5_card", card, 2'b11);
    chk("t5_sck", spi_clock, 0);
    chk("t5_mosi", spi_dataout, 1);
    chk("t5_done", cpu_done, 0);
    chk("t5_rdata", cpu_rdata, 8'hFF);
    chk("t5_busy", cpu_busy, 0);
    pulses = 0;
    repeat (40) begin
      @(negedge clock);
      if (cpu_done === 1'b1 || ldr_done === 1'b1) pulses++;
    end
    chk("t5_no_done", pulses, 0);
    cpu_single(1'b1, 8'h81, 2'b01, 8'h42, lat);
    chk("t5_after_latency", lat, 18);
    chk("t5_after_rdata", cpu_rdata, 8'h42);

    // slower SPI clock
    b3 = 8'($urandom); w3 = 8'($urandom);
    arm(8'hFF, b3);
    c3_wr = 1'b1; c3_wdata = w3; c3_cs = 2'b01; c3_req = 1'b1;
    t0 = cyc; t = 0;
    do begin @(negedge clock); t++; end while (c3_done !== 1'b1 && t < 300);
    if (t >= 300) chk("t6_done_seen", c3_done, 1);
    c3_req = 1'b0;
    chk("t6_latency", cyc - t0, 50);
    chk("t6_rdata", c3_rdata, b3);
    repeat (3) @(negedge clock);
    chk("t6_mosi", m3_byte, w3);
    chk("t6_pulses", rises3, 8);
    chk("t6_period", period3, 6);
    chk("t6_card", card3, 2'b01);

    // randomized rounds
    for (int r = 0; r < 24; r++) begin
      int cn, ln;
      bit lk;
      cn = $urandom_range(0, 1);
      ln = $urandom_range(0, 3);
      if (cn + ln == 0) ln = 1;
      lk = 1'($urandom_range(0, 1));
      run_round(cn, ln, lk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
